// File: rtl/ring_router_pkg.sv
// Shared constants and helpers for the 3-port ring router.
// Port indices, one-hot crossbar selects and lock FSM states.
package ring_router_pkg;

    localparam int NPORT  = 3;
    localparam int DEST_W = 2;

    localparam logic [DEST_W-1:0] PORT_LOCAL   = 2'd0;
    localparam logic [DEST_W-1:0] PORT_CW      = 2'd1;
    localparam logic [DEST_W-1:0] PORT_CCW     = 2'd2;
    localparam logic [DEST_W-1:0] PORT_ILLEGAL = 2'd3;

    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_I0   = 3'b001;
    localparam logic [2:0] SEL_I1   = 3'b010;
    localparam logic [2:0] SEL_I2   = 3'b100;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    function automatic logic [DEST_W-1:0] oh2idx(input logic [2:0] oh);
        logic [DEST_W-1:0] idx;
        idx = PORT_LOCAL;
        unique case (1'b1)
            oh[1]:   idx = PORT_CW;
            oh[2]:   idx = PORT_CCW;
            default: idx = PORT_LOCAL;
        endcase
        return idx;
    endfunction

    function automatic logic [DEST_W-1:0] next_ptr(input logic [DEST_W-1:0] idx);
        return (idx == PORT_CCW) ? PORT_LOCAL : idx + 2'd1;
    endfunction

endpackage

// File: rtl/rr_arb3.sv
// Combinational 3-way round-robin arbiter.
// Scans ptr, ptr+1, ptr+2 (mod 3) and grants the first requester one-hot.
module rr_arb3
    import ring_router_pkg::*;
(
    input  logic [2:0]        req,
    input  logic [DEST_W-1:0] ptr,
    output logic [2:0]        gnt
);

    always_comb begin
        gnt = SEL_NONE;
        unique case (ptr)
            2'd1: begin
                if (req[1])      gnt = SEL_I1;
                else if (req[2]) gnt = SEL_I2;
                else if (req[0]) gnt = SEL_I0;
            end
            2'd2: begin
                if (req[2])      gnt = SEL_I2;
                else if (req[0]) gnt = SEL_I0;
                else if (req[1]) gnt = SEL_I1;
            end
            default: begin
                if (req[0])      gnt = SEL_I0;
                else if (req[1]) gnt = SEL_I1;
                else if (req[2]) gnt = SEL_I2;
            end
        endcase
    end

endmodule

// File: rtl/ring_switch_allocator.sv
// Switch allocator for the 3x3 ring router crossbar.
// Per-output round-robin lock held for a wormhole packet until its tail.
module ring_switch_allocator
    import ring_router_pkg::*;
#(
    parameter int SEL_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        in_valid,
    input  logic [DEST_W-1:0] in_dest0,
    input  logic [DEST_W-1:0] in_dest1,
    input  logic [DEST_W-1:0] in_dest2,
    input  logic [2:0]        in_tail,
    input  logic [2:0]        out_ready,
    output logic [2:0]        in_ack,
    output logic [SEL_W-1:0]  sel0,
    output logic [SEL_W-1:0]  sel1,
    output logic [SEL_W-1:0]  sel2,
    output logic [2:0]        out_valid,
    output logic              err_dest
);

    logic [DEST_W-1:0] dest    [NPORT];
    logic [0:0]        st_q    [NPORT];
    logic [DEST_W-1:0] owner_q [NPORT];
    logic [DEST_W-1:0] ptr_q   [NPORT];
    logic [2:0]        sel_q   [NPORT];
    logic [2:0]        req     [NPORT];
    logic [2:0]        gnt     [NPORT];
    logic [2:0]        busy;
    logic [2:0]        xfer;
    logic [2:0]        ov_q;
    logic              err_d;
    logic              err_q;

    assign dest[0] = in_dest0;
    assign dest[1] = in_dest1;
    assign dest[2] = in_dest2;

    // An input that already owns an output must not request another one.
    always_comb begin
        busy = '0;
        for (int o = 0; o < NPORT; o++) begin
            for (int i = 0; i < NPORT; i++) begin
                if (st_q[o] == ST_LOCKED && owner_q[o] == 2'(i))
                    busy[i] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int o = 0; o < NPORT; o++) begin
            req[o] = '0;
            for (int i = 0; i < NPORT; i++) begin
                req[o][i] = in_valid[i] & ~busy[i] & (dest[i] == 2'(o));
            end
        end
    end

    always_comb begin
        xfer   = '0;
        in_ack = '0;
        for (int o = 0; o < NPORT; o++) begin
            xfer[o] = (st_q[o] == ST_LOCKED) & in_valid[owner_q[o]]
                    & out_ready[o];
            for (int i = 0; i < NPORT; i++) begin
                if (xfer[o] && owner_q[o] == 2'(i))
                    in_ack[i] = 1'b1;
            end
        end
    end

    always_comb begin
        err_d = 1'b0;
        for (int i = 0; i < NPORT; i++) begin
            if (in_valid[i] && !busy[i] && dest[i] == PORT_ILLEGAL)
                err_d = 1'b1;
        end
    end

    for (genvar g = 0; g < NPORT; g++) begin : g_arb
        rr_arb3 u_arb (
            .req (req[g]),
            .ptr (ptr_q[g]),
            .gnt (gnt[g])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int o = 0; o < NPORT; o++) begin
                st_q[o]    <= ST_IDLE;
                owner_q[o] <= PORT_LOCAL;
                ptr_q[o]   <= PORT_LOCAL;
                sel_q[o]   <= SEL_NONE;
            end
            ov_q  <= '0;
            err_q <= 1'b0;
        end else begin
            for (int o = 0; o < NPORT; o++) begin
                if (st_q[o] == ST_IDLE) begin
                    if (|req[o]) begin
                        st_q[o]    <= ST_LOCKED;
                        owner_q[o] <= oh2idx(gnt[o]);
                        sel_q[o]   <= gnt[o];
                    end
                end else if (xfer[o] && in_tail[owner_q[o]]) begin
                    st_q[o]  <= ST_IDLE;
                    ptr_q[o] <= next_ptr(owner_q[o]);
                    sel_q[o] <= SEL_NONE;
                end
            end
            ov_q  <= xfer;
            err_q <= err_d;
        end
    end

    assign sel0      = SEL_W'(sel_q[0]);
    assign sel1      = SEL_W'(sel_q[1]);
    assign sel2      = SEL_W'(sel_q[2]);
    assign out_valid = ov_q;
    assign err_dest  = err_q;

endmodule

// File: tb/tb_ring_switch_allocator.sv
// Directed testbench for ring_switch_allocator.
// Inputs change 1 time unit after the rising edge; outputs checked 1 unit later.
module tb_ring_switch_allocator;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] in_valid = '0;
    logic [1:0] in_dest0 = '0;
    logic [1:0] in_dest1 = '0;
    logic [1:0] in_dest2 = '0;
    logic [2:0] in_tail = '0;
    logic [2:0] out_ready = '0;
    logic [2:0] in_ack;
    logic [4:0] sel0;
    logic [4:0] sel1;
    logic [4:0] sel2;
    logic [2:0] out_valid;
    logic       err_dest;

    int n_run  = 0;
    int n_fail = 0;

    ring_switch_allocator dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_dest0  (in_dest0),
        .in_dest1  (in_dest1),
        .in_dest2  (in_dest2),
        .in_tail   (in_tail),
        .out_ready (out_ready),
        .in_ack    (in_ack),
        .sel0      (sel0),
        .sel1      (sel1),
        .sel2      (sel2),
        .out_valid (out_valid),
        .err_dest  (err_dest)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = '0;
        in_tail   = '0;
        in_dest0  = '0;
        in_dest1  = '0;
        in_dest2  = '0;
        out_ready = 3'b111;
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            in_valid  = 3'($urandom);
            in_tail   = 3'($urandom);
            out_ready = 3'($urandom);
            in_dest0  = 2'($urandom);
            in_dest1  = 2'($urandom);
            in_dest2  = 2'($urandom);
            #1;
            n_run++;
            if ({sel0, sel1, sel2, in_ack, out_valid, err_dest} !== 22'd0) begin
                n_fail++;
                $display("FAIL reset_hold c%0d: sel %b %b %b ack %b ov %b err %b want all 0",
                         c, sel0, sel1, sel2, in_ack, out_valid, err_dest);
            end
        end
        in_valid = '0;
        in_tail  = '0;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            #1;
            n_run++;
            if ({sel0, sel1, sel2, in_ack, out_valid, err_dest} !== 22'd0) begin
                n_fail++;
                $display("FAIL reset_idle c%0d: sel %b %b %b ack %b ov %b err %b want all 0",
                         c, sel0, sel1, sel2, in_ack, out_valid, err_dest);
            end
        end
    endtask

    task automatic test_single_flit();
        do_reset();
        step();
        in_valid = 3'b001;
        in_dest0 = 2'd1;
        in_tail  = 3'b001;
        #1;
        n_run++;
        if (in_ack !== 3'b000 || sel1 !== 5'b0) begin
            n_fail++;
            $display("FAIL single_c0: ack %b sel1 %b want 000 00000", in_ack, sel1);
        end
        step();
        n_run++;
        if (sel1 !== 5'b00001 || in_ack !== 3'b001) begin
            n_fail++;
            $display("FAIL single_c1: sel1 %b ack %b want 00001 001", sel1, in_ack);
        end
        step();
        in_valid = 3'b000;
        in_tail  = 3'b000;
        #1;
        n_run++;
        if (out_valid !== 3'b010 || sel1 !== 5'b0 || in_ack !== 3'b000) begin
            n_fail++;
            $display("FAIL single_c2: ov %b sel1 %b ack %b want 010 00000 000",
                     out_valid, sel1, in_ack);
        end
    endtask

    task automatic test_contention();
        logic [2:0] tv [10];
        logic [2:0] tt [10];
        logic [2:0] es [10];
        logic [2:0] ea [10];
        logic [2:0] eov;
        tv = '{3'b111, 3'b111, 3'b111, 3'b110, 3'b110,
               3'b110, 3'b100, 3'b100, 3'b100, 3'b000};
        tt = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b000,
               3'b010, 3'b000, 3'b000, 3'b100, 3'b000};
        es = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b010,
               3'b010, 3'b000, 3'b100, 3'b100, 3'b000};
        ea = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b010,
               3'b010, 3'b000, 3'b100, 3'b100, 3'b000};
        do_reset();
        in_dest0 = 2'd2;
        in_dest1 = 2'd2;
        in_dest2 = 2'd2;
        for (int c = 0; c < 10; c++) begin
            step();
            in_valid = tv[c];
            in_tail  = tt[c];
            #1;
            eov = (c > 0 && ea[c-1] != 3'b000) ? 3'b100 : 3'b000;
            n_run++;
            if (sel2 !== {2'b00, es[c]} || in_ack !== ea[c] || out_valid !== eov) begin
                n_fail++;
                $display("FAIL contention c%0d: sel2 %b ack %b ov %b want %b %b %b",
                         c, sel2, in_ack, out_valid, es[c], ea[c], eov);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [2:0] tv [8];
        logic [2:0] tt [8];
        logic [2:0] tr [8];
        logic [2:0] es [8];
        logic [2:0] ea [8];
        logic [2:0] eo [8];
        tv = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b000};
        tt = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000};
        tr = '{3'b111, 3'b111, 3'b110, 3'b110, 3'b110, 3'b111, 3'b111, 3'b111};
        es = '{3'b000, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b000};
        ea = '{3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b010, 3'b010, 3'b000};
        eo = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b001, 3'b001};
        do_reset();
        in_dest1 = 2'd0;
        for (int c = 0; c < 8; c++) begin
            step();
            in_valid  = tv[c];
            in_tail   = tt[c];
            out_ready = tr[c];
            #1;
            n_run++;
            if (sel0 !== {2'b00, es[c]} || in_ack !== ea[c] || out_valid !== eo[c]) begin
                n_fail++;
                $display("FAIL backpressure c%0d: sel0 %b ack %b ov %b want %b %b %b",
                         c, sel0, in_ack, out_valid, es[c], ea[c], eo[c]);
            end
        end
    endtask

    task automatic test_parallel();
        do_reset();
        step();
        in_dest0 = 2'd2;
        in_dest1 = 2'd0;
        in_dest2 = 2'd1;
        in_valid = 3'b111;
        in_tail  = 3'b000;
        #1;
        n_run++;
        if (in_ack !== 3'b000) begin
            n_fail++;
            $display("FAIL parallel_c0: ack %b want 000", in_ack);
        end
        step();
        n_run++;
        if (sel0 !== 5'b00010 || sel1 !== 5'b00100 || sel2 !== 5'b00001
            || in_ack !== 3'b111) begin
            n_fail++;
            $display("FAIL parallel_c1: sel %b %b %b ack %b want 00010 00100 00001 111",
                     sel0, sel1, sel2, in_ack);
        end
        step();
        in_tail = 3'b111;
        #1;
        n_run++;
        if (in_ack !== 3'b111 || out_valid !== 3'b111) begin
            n_fail++;
            $display("FAIL parallel_c2: ack %b ov %b want 111 111", in_ack, out_valid);
        end
        step();
        in_valid = 3'b000;
        in_tail  = 3'b000;
        #1;
        n_run++;
        if ({sel0, sel1, sel2} !== 15'd0 || out_valid !== 3'b111 || in_ack !== 3'b000) begin
            n_fail++;
            $display("FAIL parallel_c3: sel %b %b %b ov %b ack %b want 0 0 0 111 000",
                     sel0, sel1, sel2, out_valid, in_ack);
        end
    endtask

    task automatic test_error_and_reset();
        do_reset();
        step();
        in_valid = 3'b100;
        in_dest2 = 2'd3;
        #1;
        n_run++;
        if (err_dest !== 1'b0) begin
            n_fail++;
            $display("FAIL err_c0: err %b want 0", err_dest);
        end
        step();
        n_run++;
        if (err_dest !== 1'b1 || {sel0, sel1, sel2} !== 15'd0 || in_ack !== 3'b000) begin
            n_fail++;
            $display("FAIL err_c1: err %b sel %b %b %b ack %b want 1 0 0 0 000",
                     err_dest, sel0, sel1, sel2, in_ack);
        end
        step();
        in_valid = 3'b000;
        in_dest2 = 2'd0;
        #1;
        step();
        n_run++;
        if (err_dest !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: err %b want 0", err_dest);
        end
        // Single flit i0->o1 moves output 1's pointer to 1.
        in_valid = 3'b001;
        in_dest0 = 2'd1;
        in_tail  = 3'b001;
        step();
        n_run++;
        if (sel1 !== 5'b00001 || in_ack !== 3'b001) begin
            n_fail++;
            $display("FAIL rr_prep: sel1 %b ack %b want 00001 001", sel1, in_ack);
        end
        step();
        in_valid = 3'b011;
        in_dest1 = 2'd1;
        in_tail  = 3'b000;
        #1;
        step();
        n_run++;
        if (sel1 !== 5'b00010 || in_ack !== 3'b010) begin
            n_fail++;
            $display("FAIL rr_ptr1: sel1 %b ack %b want 00010 010", sel1, in_ack);
        end
        #2;
        rst = 1'b0;
        #1;
        n_run++;
        if (sel1 !== 5'b0 || in_ack !== 3'b000 || out_valid !== 3'b000) begin
            n_fail++;
            $display("FAIL async_rst: sel1 %b ack %b ov %b want 0 000 000",
                     sel1, in_ack, out_valid);
        end
        step();
        step();
        rst = 1'b1;
        step();
        n_run++;
        if (sel1 !== 5'b00001 || in_ack !== 3'b001) begin
            n_fail++;
            $display("FAIL post_rst_grant: sel1 %b ack %b want 00001 001", sel1, in_ack);
        end
    endtask

    initial begin
        test_reset();
        test_single_flit();
        test_contention();
        test_backpressure();
        test_parallel();
        test_error_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
